// File: rtl/mux_pipe.sv
// NUM_INPUTS:1 selector with one registered output stage and valid/ready flow.
// Illegal selects yield zero data, an error flag, a sticky error and a counter.
module mux_pipe #(
   parameter int NUM_INPUTS = 31,
   parameter int WIDTH      = 2,
   parameter int SEL_W      = 5,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SEL_W-1:0]            sel,
   input  logic [NUM_INPUTS*WIDTH-1:0] inp_flat,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out,
   output logic                        out_err,
   output logic                        err_sticky,
   output logic [ERR_CNT_W-1:0]        err_count,
   input  logic                        err_clear
);

   typedef enum logic {
      EMPTY,
      FULL
   } state_t;

   // One extra bit so NUM_INPUTS == 2**SEL_W is representable.
   localparam logic [SEL_W:0]     NUM_SEL = NUM_INPUTS[SEL_W:0];
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             illegal;
   logic [WIDTH-1:0] sel_data;

   assign illegal = ({1'b0, sel} >= NUM_SEL);
   assign accept  = in_valid && in_ready;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (!illegal && sel == SEL_W'(i))
            sel_data = inp_flat[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      in_ready  = 1'b1;
      unique case (state)
         EMPTY: begin
            if (in_valid)
               state_nxt = FULL;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready && !in_valid)
               state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out     <= '0;
         out_err <= 1'b0;
      end else if (accept) begin
         out     <= sel_data;
         out_err <= illegal;
      end
   end

   // An illegal accept beats a same-cycle clear: the count restarts at one.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else if (accept && illegal) begin
         err_sticky <= 1'b1;
         if (err_clear)
            err_count <= CNT_ONE;
         else if (err_count != CNT_MAX)
            err_count <= err_count + CNT_ONE;
      end else if (err_clear) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end
   end

endmodule
